// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NREQ requesters: latches the winning word, runs the
// txStart/txDoneTick handshake and times the frame with sTick. Define UART_TX_ARB_FIXED_PRIO_EN
// for fixed lowest-index-wins priority; round-robin is built otherwise.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_BITS = 8,
  parameter int SB_TICK   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sTick,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_BITS-1:0] reqData,
  output logic [NREQ-1:0]           gnt,
  output logic                      txStart,
  output logic [DATA_BITS-1:0]      txData,
  input  logic                      txDoneTick,
  output logic                      busy,
  output logic [1:0]                owner
);

  localparam int          TOTAL     = 16 * (1 + DATA_BITS) + SB_TICK;
  localparam logic [11:0] LAST_TICK = 12'(TOTAL - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    FRAME
  } stateT;

  stateT                 stateReg, stateNext;
  logic [NREQ-1:0]       gntReg, gntNext;
  logic                  txStartReg, txStartNext;
  logic [DATA_BITS-1:0]  txDataReg, txDataNext;
  logic [1:0]            ownerReg, ownerNext;
  logic [11:0]           tickCntReg, tickCntNext;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
  logic [1:0]            lastOwnerReg, lastOwnerNext;
`endif

  logic [DATA_BITS-1:0]  words [NREQ];
  logic                  winValid;
  logic [1:0]            winIdx;
  logic [DATA_BITS-1:0]  winWord;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : gWords
      assign words[gi] = reqData[gi*DATA_BITS +: DATA_BITS];
    end
  endgenerate

  // Winner selection: the last assignment in scan order wins, so loops run from low to high priority.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    winWord  = '0;
`ifdef UART_TX_ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winValid = 1'b1;
        winIdx   = 2'(i);
        winWord  = words[i];
      end
    end
`else
    // Indices at or below lastOwner come last in the rotation; those above it override them.
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i <= int'(lastOwnerReg))) begin
        winValid = 1'b1;
        winIdx   = 2'(i);
        winWord  = words[i];
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i > int'(lastOwnerReg))) begin
        winValid = 1'b1;
        winIdx   = 2'(i);
        winWord  = words[i];
      end
    end
`endif
  end

  always_comb begin
    stateNext     = stateReg;
    gntNext       = '0;
    txStartNext   = txStartReg;
    txDataNext    = txDataReg;
    ownerNext     = ownerReg;
    tickCntNext   = tickCntReg;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
    lastOwnerNext = lastOwnerReg;
`endif
    case (stateReg)
      IDLE: begin
        if (winValid) begin
          for (int i = 0; i < NREQ; i++) begin
            gntNext[i] = (winIdx == 2'(i));
          end
          txStartNext   = 1'b1;
          txDataNext    = winWord;
          ownerNext     = winIdx;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
          lastOwnerNext = winIdx;
`endif
          stateNext     = LAUNCH;
        end
      end
      LAUNCH: begin
        // A tick arriving on the acknowledge edge belongs to no frame position yet.
        if (txDoneTick) begin
          txStartNext = 1'b0;
          tickCntNext = '0;
          stateNext   = FRAME;
        end
      end
      FRAME: begin
        if (sTick) begin
          if (tickCntReg == LAST_TICK) begin
            tickCntNext = '0;
            stateNext   = IDLE;
          end else begin
            tickCntNext = tickCntReg + 12'd1;
          end
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateReg     <= IDLE;
      gntReg       <= '0;
      txStartReg   <= 1'b0;
      txDataReg    <= '0;
      ownerReg     <= '0;
      tickCntReg   <= '0;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      lastOwnerReg <= 2'(NREQ - 1);
`endif
    end else begin
      stateReg     <= stateNext;
      gntReg       <= gntNext;
      txStartReg   <= txStartNext;
      txDataReg    <= txDataNext;
      ownerReg     <= ownerNext;
      tickCntReg   <= tickCntNext;
`ifndef UART_TX_ARB_FIXED_PRIO_EN
      lastOwnerReg <= lastOwnerNext;
`endif
    end
  end

  assign gnt     = gntReg;
  assign txStart = txStartReg;
  assign txData  = txDataReg;
  assign owner   = ownerReg;
  assign busy    = (stateReg != IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART transmitter among up to four requesters, such as the PLC core's serial output port and the peripheral message sources. Arbitration is round-robin. The block latches the winning word, launches one frame with a `txStart`/`txDoneTick` handshake, and holds the word stable for the whole frame. It tracks frame duration by counting `sTick`, so it knows when the transmitter is idle again. It sits between the requesters' TX FIFOs and the transmitter's `din`/`txStart`/`txDoneTick` pins.

## Interface
Parameters:
- `NREQ`, 4: number of requesters, legal range 2..4.
- `DATA_BITS`, 8: bits per frame. Must equal the transmitter's data width.
- `SB_TICK`, 16: stop-bit length in `sTick` units. Must equal the transmitter's value.

Ports:
- `clk` input 1: system clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low. 0 resets immediately; release is synchronised externally.
- `sTick` input 1: baud ×16 enable, shared with the transmitter.
- `req` input NREQ: per-requester level request ("word available").
- `reqData` input NREQ*DATA_BITS: packed words. Requester i uses bits [i*DATA_BITS +: DATA_BITS].
- `gnt` output NREQ: one-hot, one-cycle pop strobe to the winning requester.
- `txStart` output 1: start request to the transmitter.
- `txData` output DATA_BITS: word driven to the transmitter `din`.
- `txDoneTick` input 1: transmitter acknowledge, high while the transmitter is idle and `txStart` is high.
- `busy` output 1: high whenever state is not IDLE.
- `owner` output 2: index of the current or last granted requester.

## Operation
States: IDLE, LAUNCH, FRAME.

- **Reset:**
  - state = IDLE.
  - `gnt` = 0, `txStart` = 0, `txData` = 0, `busy` = 0, `owner` = 0.
  - `tickCnt` = 0.
  - `lastOwner` = NREQ-1, so `req[0]` wins first.
- **IDLE:**
  - With `req` = 0, nothing happens.
  - With any `req` bit set, pick the winner w:
    - Scan order is `lastOwner`+1, +2, … modulo NREQ.
    - The first set bit wins.
  - On that edge:
    - `txData` ← word w.
    - `gnt[w]` ← 1.
    - `txStart` ← 1.
    - `owner` and `lastOwner` ← w.
    - Go to LAUNCH.
- **LAUNCH:**
  - `gnt` returns to 0 on the next edge.
  - `txStart` holds until `txDoneTick` is sampled high.
  - On that edge: `txStart` ← 0, `tickCnt` ← 0, go to FRAME.
- **FRAME:**
  - Each `sTick` increments `tickCnt` (12 bits).
  - Frame length is TOTAL = 16·(1+DATA_BITS) + SB_TICK, which is 160 for the defaults.
  - When `sTick` is high and `tickCnt` = TOTAL-1: go to IDLE, clear `tickCnt`. The transmitter reaches idle on the same edge.
- **`txData` stability:** holds the latched word through LAUNCH and FRAME, because the transmitter re-samples `din` throughout its start bit. It is updated only on a grant.
- **`req` sampling:** `req` is ignored outside IDLE. At most one grant per frame.
- **Stale request:** a requester deasserting `req` before a grant is simply skipped. No grant is issued to it.

## Timing
- **Grant latency:** `req` high at edge k in IDLE gives `gnt`/`txStart` high in cycle k+1.
- **Handshake:** `txDoneTick` is combinationally high in cycle k+1, so `txStart` falls at edge k+1. `txStart` is therefore a one-cycle pulse against a compliant transmitter. A stalled transmitter stretches it indefinitely.
- **Frame occupancy:** `busy` is high from cycle k+1 until the edge consuming sTick number TOTAL after the acknowledge.
- **Back-to-back frames:** the next grant can be issued on the edge after returning to IDLE, so the minimum gap is one clock. Never two `gnt` pulses without an intervening FRAME.
- **Simultaneous events:**
  - `sTick` in the LAUNCH→FRAME cycle is not counted.
  - Requests that change while in FRAME take effect only in IDLE.
- **Reset mid-frame:** outputs return to reset values immediately. The transmitter shares the reset source, so no partial frame continues.

## Configuration
- **`UART_TX_ARB_FIXED_PRIO_EN` defined:** fixed priority; the lowest-index set `req` always wins. `lastOwner` is not used for selection, but `owner` is still reported.
- **Undefined (default):** round-robin as described under Operation.

## Test plan
- **Single grant:** reset, then `req` = 0001, `reqData[7:0]` = 0xA5.
  - Expect `gnt` = 0001 for one cycle and `txData` = 0xA5.
  - Expect a single `txStart` pulse, then `busy` high for exactly 160 `sTick`.
  - Expect `tx` serial 0,1,0,1,0,0,1,0,1,1.
- **Round-robin rotation:** all `req` held high with words 0x11/0x22/0x33/0x44.
  - Expect grant order 0,1,2,3,0.
  - Expect `owner` to track, and each frame to complete before the next `gnt`.
- **Stalled transmitter:** hold `txDoneTick` = 0.
  - Expect `txStart` to stay high, the state to stay in LAUNCH, and no `sTick` counted.
  - Release `txDoneTick`: expect `txStart` to fall on that edge.
- **Reset mid-frame:** assert `reset` = 0 at tick 70 of a frame.
  - Expect `busy`/`txStart`/`gnt`/`txData` = 0 immediately.
  - After release, expect `req[0]` to win first.
- **Fixed priority:** with `UART_TX_ARB_FIXED_PRIO_EN` defined, `req` = 1010 held.
  - Expect requester 1 granted every frame and requester 3 never granted.
- **Stale request:** `req[2]` pulses for one cycle during FRAME.
  - Expect no grant to requester 2 on return to IDLE.
